// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared core constants and types: immediate-source encodings,
//                fetch queue defaults and the queue entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // Immediate-format select used by the downstream immediate extender
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Default number of fetch queue entries
    localparam int          FQ_DEPTH     = 4;
    // addi x0, x0, 0 -- handed to decode whenever the queue is empty
    localparam logic [31:0] FQ_NOP_INSTR = 32'h0000_0013;

    // One queue entry, PC in the upper half
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Fetch-to-decode handshake bundle. The master side is the
//                fetch/decode environment, the slave side is the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          InValid;
    logic          InReady;
    logic [31:0]   InInstr;
    logic [31:0]   InPC;
    logic          Flush;
    logic          OutValid;
    logic          OutReady;
    logic [31:0]   OutInstr;
    logic [31:0]   OutPC;
    logic [CW-1:0] Count;

    modport master (
        output InValid, InInstr, InPC, Flush, OutReady,
        input  InReady, OutValid, OutInstr, OutPC, Count
    );

    modport slave (
        input  InValid, InInstr, InPC, Flush, OutReady,
        output InReady, OutValid, OutInstr, OutPC, Count
    );

endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_mem
//  Description : DEPTH x DW register array, one synchronous write port, one
//                asynchronous read port, cleared by asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [DW-1:0] wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes, and only on a write
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage registers, wiped immediately when reset asserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : fetch_queue_mem
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Circular instruction queue between fetch and decode. Ready
//                and valid come only from registered occupancy, so there is
//                no same-cycle bypass and no input-to-handshake path.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = FQ_DEPTH,
    parameter logic [31:0] NOP_INSTR = FQ_NOP_INSTR
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fetch_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic          mem_we;
    fq_entry_t     wr_entry;
    fq_entry_t     head_entry;

    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != '0);

    // Handshake qualification; a flush suppresses the storage write as well
    always_comb begin
        push           = bus.InValid && in_ready;
        pop            = out_valid && bus.OutReady;
        mem_we         = push && !bus.Flush;
        wr_entry.pc    = bus.InPC;
        wr_entry.instr = bus.InInstr;
    end

    // Pointer and occupancy next state; flush overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (64)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (head_entry)
    );

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.OutInstr = out_valid ? head_entry.instr : NOP_INSTR;
    assign bus.OutPC    = out_valid ? head_entry.pc    : 32'h0;
    assign bus.Count    = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue (DEPTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.InValid  = 1'b0;
        bus.InInstr  = 32'h0;
        bus.InPC     = 32'h0;
        bus.Flush    = 1'b0;
        bus.OutReady = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        bus.InValid = 1'b1;
        bus.InPC    = pc;
        bus.InInstr = instr;
        tick();
        bus.InValid = 1'b0;
    endtask

    logic [31:0] fill_instr [4];
    logic [31:0] mdl_pc    [$];
    logic [31:0] mdl_instr [$];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        fill_instr[0] = 32'h0050_0093;
        fill_instr[1] = 32'h00A0_0113;
        fill_instr[2] = 32'h0020_81B3;
        fill_instr[3] = 32'hFE00_0EE3;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check("rst_outvalid", 32'(bus.OutValid), 32'd0);
        check("rst_inready",  32'(bus.InReady),  32'd1);
        check("rst_outinstr", bus.OutInstr,      NOP);
        check("rst_outpc",    bus.OutPC,         32'h0);
        check("rst_count",    32'(bus.Count),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(bus.Count), 32'd0);

        // ---------------- fill with no bypass ----------------
        bus.InValid = 1'b1;
        bus.InPC    = 32'h0;
        bus.InInstr = fill_instr[0];
        #1;
        check("no_bypass_outvalid", 32'(bus.OutValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            push_one(32'(4 * i), fill_instr[i]);
            check($sformatf("fill_count%0d", i), 32'(bus.Count), 32'(i + 1));
        end
        check("full_inready",  32'(bus.InReady),  32'd0);
        check("full_outvalid", 32'(bus.OutValid), 32'd1);
        check("full_outpc",    bus.OutPC,         32'h0);
        check("full_outinstr", bus.OutInstr,      32'h0050_0093);

        // ---------------- full with pop: push refused ----------------
        bus.InValid  = 1'b1;
        bus.InPC     = 32'h40;
        bus.InInstr  = 32'hDEAD_BEEF;
        bus.OutReady = 1'b1;
        tick();
        idle_inputs();
        check("fullpop_count",   32'(bus.Count),   32'd3);
        check("fullpop_outpc",   bus.OutPC,        32'h4);
        check("fullpop_instr",   bus.OutInstr,     32'h00A0_0113);
        check("fullpop_inready", 32'(bus.InReady), 32'd1);

        // drain; the refused word must never appear
        for (int i = 1; i < 4; i++) begin
            check($sformatf("drain_pc%0d", i),    bus.OutPC,    32'(4 * i));
            check($sformatf("drain_instr%0d", i), bus.OutInstr, fill_instr[i]);
            bus.OutReady = 1'b1;
            tick();
            bus.OutReady = 1'b0;
        end
        check("drained_outvalid", 32'(bus.OutValid), 32'd0);
        check("drained_instr",    bus.OutInstr,      NOP);

        // ---------------- pop request while empty is ignored ----------------
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
        check("empty_pop_count", 32'(bus.Count), 32'd0);

        // ---------------- wrap-around streaming with scoreboard ----------------
        for (int i = 0; i < 12; i++) begin
            logic do_push;
            logic do_pop;
            do_push      = (i < 10);
            bus.InValid  = do_push;
            bus.InPC     = 32'h100 + 32'(4 * i);
            bus.InInstr  = 32'h1000_0000 + 32'(i);
            bus.OutReady = 1'b1;
            do_pop       = (mdl_pc.size() > 0);
            if (do_pop) begin
                check($sformatf("wrap_pc%0d", i),    bus.OutPC,    mdl_pc[0]);
                check($sformatf("wrap_instr%0d", i), bus.OutInstr, mdl_instr[0]);
            end
            tick();
            if (do_pop) begin
                void'(mdl_pc.pop_front());
                void'(mdl_instr.pop_front());
            end
            if (do_push) begin
                mdl_pc.push_back(32'h100 + 32'(4 * i));
                mdl_instr.push_back(32'h1000_0000 + 32'(i));
            end
            check($sformatf("wrap_count%0d", i), 32'(bus.Count), 32'(mdl_pc.size()));
        end
        idle_inputs();
        check("wrap_empty", 32'(bus.OutValid), 32'd0);

        // ---------------- flush dominates push and pop ----------------
        push_one(32'h200, 32'h0011_0113);
        push_one(32'h204, 32'h0022_0213);
        check("preflush_count", 32'(bus.Count), 32'd2);
        bus.InValid  = 1'b1;
        bus.InPC     = 32'h208;
        bus.InInstr  = 32'h0033_0313;
        bus.OutReady = 1'b1;
        bus.Flush    = 1'b1;
        tick();
        idle_inputs();
        check("flush_count",    32'(bus.Count),    32'd0);
        check("flush_outvalid", 32'(bus.OutValid), 32'd0);
        check("flush_outinstr", bus.OutInstr,      NOP);
        check("flush_outpc",    bus.OutPC,         32'h0);
        push_one(32'h300, 32'h1234_5678);
        check("postflush_pc",    bus.OutPC,    32'h300);
        check("postflush_instr", bus.OutInstr, 32'h1234_5678);

        // ---------------- simultaneous push/pop at Count=1 ----------------
        bus.InValid  = 1'b1;
        bus.InPC     = 32'h304;
        bus.InInstr  = 32'h0000_0AB3;
        bus.OutReady = 1'b1;
        tick();
        idle_inputs();
        check("pp1_count", 32'(bus.Count), 32'd1);
        check("pp1_pc",    bus.OutPC,      32'h304);
        check("pp1_instr", bus.OutInstr,   32'h0000_0AB3);

        // ---------------- asynchronous reset mid-stream ----------------
        push_one(32'h400, 32'h0000_0001);
        push_one(32'h404, 32'h0000_0002);
        check("prerst_count", 32'(bus.Count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outvalid", 32'(bus.OutValid), 32'd0);
        check("arst_inready",  32'(bus.InReady),  32'd1);
        check("arst_outinstr", bus.OutInstr,      NOP);
        check("arst_count",    32'(bus.Count),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push_one(32'h500, 32'h0000_0555);
        check("postrst_count", 32'(bus.Count), 32'd1);
        check("postrst_pc",    bus.OutPC,      32'h500);
        check("postrst_instr", bus.OutInstr,   32'h0000_0555);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
